// File: rtl/frame_readout_sequencer_pkg.sv
// rtl/frame_readout_sequencer_pkg.sv - shared widths and sequencer state encoding
package frame_readout_sequencer_pkg;

  localparam int DATA_W = 25;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PRESENT,
    GAP,
    DONE
  } seq_state_e;

endpackage

// File: rtl/result_buffer_ram.sv
// rtl/result_buffer_ram.sv - simple dual-port result buffer, registered read port
module result_buffer_ram #(
  parameter int DATA_W = 25,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  // No reset on the array or read register so this maps onto block RAM.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/frame_readout_sequencer.sv
// rtl/frame_readout_sequencer.sv - replays a buffered address range word by word to Data_Transmit
module frame_readout_sequencer
  import frame_readout_sequencer_pkg::*;
#(
  parameter int GAP_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   frame_len,
  input  logic              abort,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] addr,
  output logic              data_valid,
  output logic              busy,
  output logic              done,
  output logic              wr_dropped
);

  localparam logic [15:0] GAP_LAST = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

  seq_state_e        state, state_nxt;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   remaining;
  logic [15:0]       gap_cnt;
  logic              zero_done;
  logic [DATA_W-1:0] ram_q;
  logic              accept;
  logic              start_ok;

  assign accept   = (state == PRESENT) && tx_ready;
  assign start_ok = (state == IDLE) && start && !abort;

  // The read register only loads in FETCH, so it holds the presented word through any stall.
  result_buffer_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en && (state == IDLE)),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (state == FETCH),
    .rd_addr (rd_ptr),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok && (frame_len != '0)) state_nxt = FETCH;
      FETCH:   state_nxt = PRESENT;
      PRESENT: begin
        if (accept) begin
          if (GAP_CYCLES > 0)                      state_nxt = GAP;
          else if (remaining == (ADDR_W+1)'(1))    state_nxt = DONE;
          else                                     state_nxt = FETCH;
        end
      end
      GAP:     if (gap_cnt == GAP_LAST) state_nxt = (remaining == '0) ? DONE : FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && (state != IDLE) && (state != DONE)) state_nxt = DONE;
  end

  always_comb begin
    data       = '0;
    addr       = '0;
    data_valid = 1'b0;
    busy       = (state != IDLE);
    done       = zero_done || (state == DONE);
    if (state == PRESENT) begin
      data       = ram_q;
      addr       = rd_ptr;
      data_valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr     <= '0;
      remaining  <= '0;
      gap_cnt    <= '0;
      zero_done  <= 1'b0;
      wr_dropped <= 1'b0;
    end else begin
      zero_done <= start_ok && (frame_len == '0);
      if (start_ok) begin
        rd_ptr     <= start_addr;
        remaining  <= frame_len;
        wr_dropped <= 1'b0;
      end else if (wr_en && busy) begin
        wr_dropped <= 1'b1;
      end
      // A word accepted alongside abort still advances the counters; it was sent.
      if (accept) begin
        rd_ptr    <= rd_ptr + ADDR_W'(1);
        remaining <= remaining - (ADDR_W+1)'(1);
        gap_cnt   <= '0;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt + 16'd1;
      end
    end
  end

endmodule
